writeback_unit: RTL

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
// Y86-64 writeback stage: one-entry buffer that decodes register destinations,
// drives the E/M register-file write ports, tracks halt and counts retirements.
module writeback_unit #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic             Cnd,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic [63:0]      valE,
  input  logic [63:0]      valM,
  input  logic             wb_stall,
  output logic             w_enE,
  output logic [3:0]       w_dstE,
  output logic [63:0]      w_valE,
  output logic             w_enM,
  output logic [3:0]       w_dstM,
  output logic [63:0]      w_valM,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam logic [3:0] IC_HALT  = 4'h0;
  localparam logic [3:0] IC_NOP   = 4'h1;

  logic [0:0]       state_q,   state_d;
  logic             valid_q,   valid_d;
  logic [3:0]       icode_q,   icode_d;
  logic             cnd_q,     cnd_d;
  logic [3:0]       ra_q,      ra_d;
  logic [3:0]       rb_q,      rb_d;
  logic [63:0]      vale_q,    vale_d;
  logic [63:0]      valm_q,    valm_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [3:0] dst_e_c;
  logic [3:0] dst_m_c;
  logic       retire_c;
  logic       accept_c;

  // Destination decode from the held entry
  always_comb begin
    dst_e_c = REG_NONE;
    dst_m_c = REG_NONE;
    unique case (icode_q)
      4'h2:                      dst_e_c = cnd_q ? rb_q : REG_NONE;
      4'h3, 4'h6:                dst_e_c = rb_q;
      4'h8, 4'h9, 4'hA, 4'hB:    dst_e_c = REG_RSP;
      default:                   dst_e_c = REG_NONE;
    endcase
    if (icode_q == 4'h5 || icode_q == 4'hB) begin
      dst_m_c = ra_q;
    end
  end

  // Handshake, retirement and write-port drive
  always_comb begin
    in_ready = !rst && (state_q == ST_RUN) && (!valid_q || !wb_stall);
    accept_c = in_valid && in_ready;
    retire_c = !rst && valid_q && !wb_stall && (state_q == ST_RUN);
    halted   = !rst && (state_q == ST_HALT);
    instret  = instret_q;
    w_dstE   = dst_e_c;
    w_valE   = vale_q;
    w_dstM   = dst_m_c;
    w_valM   = valm_q;
    // popq %rsp: the loaded value wins over the stack-pointer increment
    w_enE    = retire_c && (dst_e_c != REG_NONE) && (dst_e_c != dst_m_c);
    w_enM    = retire_c && (dst_m_c != REG_NONE);
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    icode_d   = icode_q;
    cnd_d     = cnd_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    vale_d    = vale_q;
    valm_d    = valm_q;
    instret_d = instret_q + CNT_W'(retire_c);

    if (accept_c) begin
      valid_d = 1'b1;
      icode_d = icode;
      cnd_d   = Cnd;
      ra_d    = rA;
      rb_d    = rB;
      vale_d  = valE;
      valm_d  = valM;
    end else if (retire_c) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      ST_RUN:  if (retire_c && icode_q == IC_HALT) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      valid_q   <= 1'b0;
      icode_q   <= IC_NOP;
      cnd_q     <= 1'b0;
      ra_q      <= REG_NONE;
      rb_q      <= REG_NONE;
      vale_q    <= 64'h0;
      valm_q    <= 64'h0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      icode_q   <= icode_d;
      cnd_q     <= cnd_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      vale_q    <= vale_d;
      valm_q    <= valm_d;
      instret_q <= instret_d;
    end
  end

endmodule
